watch_time_sched: RTL and testbench

//  Owns the watch time registers (hour/min/sec/msec) and arbitrates all writers to them:
//  the free-running 100 Hz tick and the edit commands from the watch control unit.

---
 rtl/watch_pkg.sv | 31 +++
 rtl/watch_autorepeat.sv | 73 +++++++
 rtl/watch_time_sched.sv | 146 ++++++++++++++
 tb/tb_watch_time_sched.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared definitions for the watch time scheduler: cursor codes, field limits,
// auto-repeat state encoding and the single-field wrap helper.
package watch_pkg;

  typedef enum logic [1:0] {
    CUR_HOUR = 2'b00,
    CUR_MIN  = 2'b01,
    CUR_SEC  = 2'b10,
    CUR_MSEC = 2'b11
  } cursor_t;

  typedef enum logic [1:0] {
    RS_IDLE   = 2'b00,
    RS_WAIT   = 2'b01,
    RS_REPEAT = 2'b10
  } rep_state_t;

  localparam logic [4:0] MAX_HOUR = 5'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_SEC  = 6'd59;
  localparam logic [6:0] MAX_MSEC = 7'd99;

  // One edit step on a field in 0..max, wrapping at both ends.
  function automatic logic [6:0] wrap_step(input logic [6:0] val,
                                           input logic [6:0] max,
                                           input logic       up);
    if (up) return (val == max) ? 7'd0 : val + 7'd1;
    else    return (val == 7'd0) ? max : val - 7'd1;
  endfunction

endpackage

// File: rtl/watch_autorepeat.sv
// Auto-repeat for held +/- buttons: waits REP_DELAY cycles after a pulse, then
// issues one step every REP_RATE cycles while the latched button stays held.
module watch_autorepeat
  import watch_pkg::*;
#(
  parameter int REP_DELAY = 50_000_000,
  parameter int REP_RATE  = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc_pulse,
  input  logic i_dec_pulse,
  input  logic i_abort,
  input  logic i_up_level,
  input  logic i_down_level,
  output logic o_step_inc,
  output logic o_step_dec,
  output logic o_repeat_active
);

  localparam int CNT_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REP_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REP_RATE - 1);

  rep_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir_up;
  logic             r_repeat_active;

  logic w_level;
  logic w_hold;
  logic w_any_pulse;
  logic w_fire;

  // Holding means the latched button is still down and the other one is not.
  assign w_level     = r_dir_up ? i_up_level : i_down_level;
  assign w_hold      = (r_state != RS_IDLE) && w_level && !(i_up_level && i_down_level);
  assign w_any_pulse = i_inc_pulse | i_dec_pulse;
  assign w_fire      = w_hold && (r_cnt == '0) && !i_abort && !w_any_pulse;

  assign o_step_inc      = w_fire &&  r_dir_up;
  assign o_step_dec      = w_fire && !r_dir_up;
  assign o_repeat_active = r_repeat_active;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= RS_IDLE;
      r_cnt           <= '0;
      r_dir_up        <= 1'b0;
      r_repeat_active <= 1'b0;
    end else if (i_abort || (i_inc_pulse && i_dec_pulse)) begin
      r_state         <= RS_IDLE;
      r_repeat_active <= 1'b0;
    end else if (w_any_pulse) begin
      r_state         <= RS_WAIT;
      r_dir_up        <= i_inc_pulse;
      r_cnt           <= DELAY_LOAD;
      r_repeat_active <= 1'b0;
    end else if (!w_hold) begin
      r_state         <= RS_IDLE;
      r_repeat_active <= 1'b0;
    end else if (r_cnt == '0) begin
      r_state         <= RS_REPEAT;
      r_cnt           <= RATE_LOAD;
      r_repeat_active <= 1'b1;
    end else begin
      r_cnt           <= r_cnt - 1'b1;
      r_repeat_active <= (r_state == RS_REPEAT);
    end
  end

endmodule

// File: rtl/watch_time_sched.sv
// Watch time registers with arbitration between reset_pulse, cursor edits
// (pulses and auto-repeat) and the 100 Hz tick, including a 1-deep pending tick.
module watch_time_sched
  import watch_pkg::*;
#(
  parameter int REP_DELAY = 50_000_000,
  parameter int REP_RATE  = 10_000_000,
  parameter int DEF_HOUR  = 12,
  parameter int DEF_MIN   = 0,
  parameter int DEF_SEC   = 0,
  parameter int DEF_MSEC  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick_100hz,
  input  logic [1:0] i_cursor,
  input  logic       i_inc_pulse,
  input  logic       i_dec_pulse,
  input  logic       i_reset_pulse,
  input  logic       i_up_level,
  input  logic       i_down_level,
  output logic [4:0] o_hour,
  output logic [5:0] o_min,
  output logic [5:0] o_sec,
  output logic [6:0] o_msec,
  output logic       o_repeat_active,
  output logic       o_tick_overrun
);

  logic [4:0] r_hour;
  logic [5:0] r_min;
  logic [5:0] r_sec;
  logic [6:0] r_msec;
  logic       r_pending;
  logic       r_overrun;

  logic       w_step_inc;
  logic       w_step_dec;
  logic       w_inc;
  logic       w_dec;
  logic       w_edit;
  cursor_t    w_cursor;
  logic [6:0] w_sel_val;
  logic [6:0] w_sel_max;
  logic [6:0] w_edit_val;
  logic [4:0] w_t_hour;
  logic [5:0] w_t_min;
  logic [5:0] w_t_sec;
  logic [6:0] w_t_msec;

  watch_autorepeat #(
    .REP_DELAY(REP_DELAY),
    .REP_RATE (REP_RATE)
  ) u_autorepeat (
    .clk            (clk),
    .reset          (reset),
    .i_inc_pulse    (i_inc_pulse),
    .i_dec_pulse    (i_dec_pulse),
    .i_abort        (i_reset_pulse),
    .i_up_level     (i_up_level),
    .i_down_level   (i_down_level),
    .o_step_inc     (w_step_inc),
    .o_step_dec     (w_step_dec),
    .o_repeat_active(o_repeat_active)
  );

  // Simultaneous increment and decrement requests cancel to no edit at all.
  assign w_cursor = cursor_t'(i_cursor);
  assign w_inc    = i_inc_pulse | w_step_inc;
  assign w_dec    = i_dec_pulse | w_step_dec;
  assign w_edit   = w_inc ^ w_dec;

  always_comb begin
    w_sel_val = 7'd0;
    w_sel_max = 7'd0;
    case (w_cursor)
      CUR_HOUR: begin w_sel_val = {2'b00, r_hour}; w_sel_max = {2'b00, MAX_HOUR}; end
      CUR_MIN:  begin w_sel_val = {1'b0, r_min};   w_sel_max = {1'b0, MAX_MIN};   end
      CUR_SEC:  begin w_sel_val = {1'b0, r_sec};   w_sel_max = {1'b0, MAX_SEC};   end
      CUR_MSEC: begin w_sel_val = r_msec;          w_sel_max = MAX_MSEC;          end
    endcase
    w_edit_val = wrap_step(w_sel_val, w_sel_max, w_inc);
  end

  // Full carry chain of a tick, resolved within one cycle.
  always_comb begin
    w_t_hour = r_hour;
    w_t_min  = r_min;
    w_t_sec  = r_sec;
    w_t_msec = r_msec + 7'd1;
    if (r_msec == MAX_MSEC) begin
      w_t_msec = 7'd0;
      w_t_sec  = r_sec + 6'd1;
      if (r_sec == MAX_SEC) begin
        w_t_sec = 6'd0;
        w_t_min = r_min + 6'd1;
        if (r_min == MAX_MIN) begin
          w_t_min  = 6'd0;
          w_t_hour = (r_hour == MAX_HOUR) ? 5'd0 : r_hour + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hour    <= 5'(DEF_HOUR);
      r_min     <= 6'(DEF_MIN);
      r_sec     <= 6'(DEF_SEC);
      r_msec    <= 7'(DEF_MSEC);
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else if (i_reset_pulse) begin
      r_hour    <= 5'(DEF_HOUR);
      r_min     <= 6'(DEF_MIN);
      r_sec     <= 6'(DEF_SEC);
      r_msec    <= 7'(DEF_MSEC);
      r_pending <= i_tick_100hz;
    end else if (w_edit) begin
      case (w_cursor)
        CUR_HOUR: r_hour <= w_edit_val[4:0];
        CUR_MIN:  r_min  <= w_edit_val[5:0];
        CUR_SEC:  r_sec  <= w_edit_val[5:0];
        CUR_MSEC: r_msec <= w_edit_val;
      endcase
      if (i_tick_100hz) begin
        if (r_pending) r_overrun <= 1'b1;
        r_pending <= 1'b1;
      end
    end else if (i_tick_100hz || r_pending) begin
      r_hour    <= w_t_hour;
      r_min     <= w_t_min;
      r_sec     <= w_t_sec;
      r_msec    <= w_t_msec;
      r_pending <= 1'b0;
      if (i_tick_100hz && r_pending) r_overrun <= 1'b1;
    end
  end

  assign o_hour         = r_hour;
  assign o_min          = r_min;
  assign o_sec          = r_sec;
  assign o_msec         = r_msec;
  assign o_tick_overrun = r_overrun;

endmodule

// File: tb/tb_watch_time_sched.sv
// Scoreboard bench for watch_time_sched: a behavioural model pushes the expected
// outputs for every driven cycle, which are popped and compared after the edge.
module tb_watch_time_sched;
  import watch_pkg::*;

  localparam int RD = 8;
  localparam int RR = 4;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [1:0] cursor;
  logic       incPulse;
  logic       decPulse;
  logic       resetPulse;
  logic       upLevel;
  logic       downLevel;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [6:0] msec;
  logic       repeatActive;
  logic       tickOverrun;

  typedef struct {
    int hour;
    int min;
    int sec;
    int msec;
    int rep;
    int ovr;
  } expect_t;

  expect_t sbQ[$];

  int checks   = 0;
  int failures = 0;

  int mH = 12, mM = 0, mS = 0, mC = 0;
  bit mPend = 0, mOvr = 0, mDirUp = 0, mActive = 0;
  int mHold = -1;

  watch_time_sched #(
    .REP_DELAY(RD),
    .REP_RATE (RR)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_tick_100hz   (tick),
    .i_cursor       (cursor),
    .i_inc_pulse    (incPulse),
    .i_dec_pulse    (decPulse),
    .i_reset_pulse  (resetPulse),
    .i_up_level     (upLevel),
    .i_down_level   (downLevel),
    .o_hour         (hour),
    .o_min          (min),
    .o_sec          (sec),
    .o_msec         (msec),
    .o_repeat_active(repeatActive),
    .o_tick_overrun (tickOverrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Behavioural model of one clock cycle; the repeater is modelled as a count of held cycles.
  task automatic modelCycle(input bit rst, input bit rp, input bit tk, input bit inc,
                            input bit dec, input bit up, input bit down, input logic [1:0] cur);
    bit stepI = 0, stepD = 0, eInc, eDec;
    int t;
    expect_t e;
    if (rst || rp || (inc && dec)) begin
      mHold = -1; mActive = 0;
    end else if (inc || dec) begin
      mDirUp = inc; mHold = 0; mActive = 0;
    end else if (mHold >= 0 && (mDirUp ? up : down) && !(up && down)) begin
      mHold = mHold + 1;
      if (mHold >= RD && ((mHold - RD) % RR) == 0) begin
        stepI = mDirUp; stepD = !mDirUp;
      end
      mActive = (mHold >= RD);
    end else begin
      mHold = -1; mActive = 0;
    end
    eInc = inc || stepI;
    eDec = dec || stepD;
    if (rst) begin
      mH = 12; mM = 0; mS = 0; mC = 0; mPend = 0; mOvr = 0;
    end else if (rp) begin
      mH = 12; mM = 0; mS = 0; mC = 0; mPend = tk;
    end else if (eInc != eDec) begin
      case (cur)
        2'b00: mH = eInc ? (mH + 1) % 24  : (mH + 23) % 24;
        2'b01: mM = eInc ? (mM + 1) % 60  : (mM + 59) % 60;
        2'b10: mS = eInc ? (mS + 1) % 60  : (mS + 59) % 60;
        default: mC = eInc ? (mC + 1) % 100 : (mC + 99) % 100;
      endcase
      if (tk) begin
        if (mPend) mOvr = 1;
        mPend = 1;
      end
    end else if (tk || mPend) begin
      t = (((mH * 60 + mM) * 60 + mS) * 100 + mC + 1) % 8640000;
      mC = t % 100; t = t / 100;
      mS = t % 60;  t = t / 60;
      mM = t % 60;  mH = t / 60;
      if (tk && mPend) mOvr = 1;
      mPend = 0;
    end
    e.hour = mH; e.min = mM; e.sec = mS; e.msec = mC;
    e.rep = mActive; e.ovr = mOvr;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input bit rst, input bit rp, input bit tk, input bit inc,
                               input bit dec, input bit up, input bit down, input logic [1:0] cur);
    expect_t e;
    reset = rst; resetPulse = rp; tick = tk; incPulse = inc; decPulse = dec;
    upLevel = up; downLevel = down; cursor = cur;
    modelCycle(rst, rp, tk, inc, dec, up, down, cur);
    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      checkOutput("sb_empty", 0, 1);
    end else begin
      e = sbQ.pop_front();
      checkOutput("hour", int'(hour), e.hour);
      checkOutput("min", int'(min), e.min);
      checkOutput("sec", int'(sec), e.sec);
      checkOutput("msec", int'(msec), e.msec);
      checkOutput("repeat_active", int'(repeatActive), e.rep);
      checkOutput("tick_overrun", int'(tickOverrun), e.ovr);
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; cursor = 2'b00; incPulse = 1'b0; decPulse = 1'b0;
    resetPulse = 1'b0; upLevel = 1'b0; downLevel = 1'b0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, CUR_HOUR);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, CUR_HOUR);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, CUR_HOUR);
    checkOutput("reset_hour", int'(hour), 12);
    checkOutput("reset_msec", int'(msec), 0);
    checkOutput("reset_overrun", int'(tickOverrun), 0);

    // Build 23:59:59.99 with edits, then one tick rolls everything over.
    for (int i = 0; i < 11; i++) applyStimulus(0, 0, 0, 1, 0, 0, 0, CUR_HOUR);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, CUR_MIN);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, CUR_SEC);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, CUR_MSEC);
    checkOutput("set_hour", int'(hour), 23);
    checkOutput("set_msec", int'(msec), 99);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, CUR_MSEC);
    checkOutput("roll_hour", int'(hour), 0);
    checkOutput("roll_min", int'(min), 0);
    checkOutput("roll_sec", int'(sec), 0);
    checkOutput("roll_msec", int'(msec), 0);
    checkOutput("roll_overrun", int'(tickOverrun), 0);

    // Edit wrap without carry.
    applyStimulus(0, 0, 0, 0, 1, 0, 0, CUR_MIN);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, CUR_MIN);
    checkOutput("minwrap_min", int'(min), 0);
    checkOutput("minwrap_hour", int'(hour), 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, CUR_HOUR);
    checkOutput("hourwrap", int'(hour), 23);

    // Tick collides with an edit, then a second tick merges with the pending one.
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 1, 0, 0, 0, CUR_MSEC);
    applyStimulus(0, 0, 1, 1, 0, 0, 0, CUR_MSEC);
    checkOutput("collide_msec", int'(msec), 11);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, CUR_MSEC);
    checkOutput("pending_msec", int'(msec), 12);
    checkOutput("overrun_set", int'(tickOverrun), 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, CUR_MSEC);
    checkOutput("overrun_sticky", int'(tickOverrun), 1);

    // inc and dec together cancel.
    applyStimulus(0, 0, 0, 1, 1, 0, 0, CUR_MSEC);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, CUR_MSEC);
    checkOutput("cancel_msec", int'(msec), 12);
    checkOutput("cancel_repeat", int'(repeatActive), 0);

    // Auto-repeat on seconds with up held for 20 cycles, then released.
    applyStimulus(0, 0, 0, 1, 0, 1, 0, CUR_SEC);
    checkOutput("rep_first", int'(sec), 1);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0, CUR_SEC);
    checkOutput("rep_active_held", int'(repeatActive), 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, CUR_SEC);
    checkOutput("rep_final_sec", int'(sec), 5);
    checkOutput("rep_released", int'(repeatActive), 0);

    // reset_pulse in REPEAT with a tick pending, then a full reset.
    applyStimulus(0, 0, 0, 1, 0, 1, 0, CUR_SEC);
    for (int i = 0; i < 11; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0, CUR_SEC);
    applyStimulus(0, 0, 1, 0, 0, 1, 0, CUR_SEC);
    applyStimulus(0, 1, 0, 0, 0, 1, 0, CUR_SEC);
    checkOutput("rp_hour", int'(hour), 12);
    checkOutput("rp_sec", int'(sec), 0);
    checkOutput("rp_repeat", int'(repeatActive), 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0, CUR_SEC);
    checkOutput("rp_no_step", int'(sec), 0);
    checkOutput("rp_no_pending", int'(msec), 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, CUR_HOUR);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, CUR_HOUR);
    checkOutput("final_hour", int'(hour), 12);
    checkOutput("final_overrun", int'(tickOverrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
